apd_hv_dac_sched: RTL and testbench
===================================

Name: apd_hv_dac_sched

Overview:
- Schedules all writes to the single APD high-voltage DAC.
- Arbitrates between two requesters: the host/config path (manual setpoint) and the temperature-compensation path (periodic computed code).
- Ramps the DAC code toward the target in bounded steps, holding a settle interval between steps.
- Drives a req/ack handshake into the serial DAC driver, with ack timeout and retry.

Parameters:
- CODE_MIN, 200, lowest legal 10-bit DAC code; requests below it are clamped up.
- CODE_MAX, 680, highest legal 10-bit DAC code; requests above it are clamped down.
- INIT_CODE, 400, code loaded and force-written after reset.
- STEP_MAX, 16, largest code change per DAC write.
- SETTLE_CYCLES, 10_000, idle clocks after each acknowledged write.
- ACK_TIMEOUT, 65_535, clocks to wait for dac_ack before aborting.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- host_valid  in  1  host setpoint request.
- host_code  in  10  host setpoint.
- host_ready  out  1  host request accepted when high.
- comp_valid  in  1  compensation request.
- comp_code  in  10  compensation setpoint.
- comp_enable  in  1  0 = compensation requests ignored (manual mode).
- dac_req  out  1  DAC write request, level, held until ack or timeout.
- dac_data  out  16  DAC word {1'b1, 3'd0, code[9:0], 2'd0}.
- dac_ack  in  1  one-cycle completion pulse from the DAC driver.
- cur_code  out  10  last acknowledged DAC code.
- target_code  out  10  current clamped target.
- busy  out  1  high when state is not IDLE.
- clamp_pulse  out  1  one-cycle pulse when an accepted code was clamped.
- ack_err  out  1  sticky; set on ack timeout.
- err_clr  in  1  clears ack_err.

Behaviour:
- Reset values:
  - state=IDLE, cur_code=INIT_CODE, target_code=INIT_CODE, init_pending=1.
  - dac_req=0, dac_data=0, clamp_pulse=0, ack_err=0, busy=0.
  - host_ready=0 while rst_n low.
- Readiness: host_ready = (state != WAIT_ACK). Compensation uses the same gating; comp has no ready and a blocked comp request is dropped.
- Arbitration (when ready):
  - host_valid wins: target_code <= clamp(host_code).
  - Otherwise, if comp_valid && comp_enable: target_code <= clamp(comp_code).
  - Same-cycle comp request loses to host and is discarded.
  - Target updates are accepted in IDLE and SETTLE; the newest target always wins.
- Clamp: clamp(x) = min(max(x, CODE_MIN), CODE_MAX). clamp_pulse asserts the cycle after an accepted request whose code was out of range.
- FSM:
  - IDLE:
    - if init_pending or cur_code != target_code: next = cur_code moved toward target_code by min(|diff|, STEP_MAX); with init_pending, next = cur_code.
    - At that edge set dac_data = {1'b1, 3'd0, next, 2'd0}, dac_req=1, ack timer=0, and go to WAIT_ACK.
    - Request-to-dac_req latency: one clock after acceptance.
  - WAIT_ACK:
    - dac_req and dac_data are stable.
    - on dac_ack: dac_req=0, cur_code=next, init_pending=0, settle counter=SETTLE_CYCLES, go to SETTLE.
    - if the timer reaches ACK_TIMEOUT without ack: dac_req=0, ack_err=1, cur_code unchanged, init_pending unchanged, go to SETTLE. The step is retried afterwards.
    - A dac_ack arriving on the timeout cycle counts as ack.
  - SETTLE: count down to 0, then go to IDLE. A target change does not shorten the settle interval.
- Arithmetic: diff is computed 11-bit signed. Steps never overshoot the target; the final step may be smaller than STEP_MAX.
- err_clr: clears ack_err. If a timeout occurs in the same cycle, set wins.
- dac_ack outside WAIT_ACK: ignored.
- Reset mid-transaction: dac_req drops immediately (asynchronous) and the init write repeats after release.

Test Plan:
1. Reset release (INIT_CODE=400, SETTLE_CYCLES=8) -> one write dac_data=16'h8640 (code 400); after ack, cur_code=400, busy drops 9 clocks after ack.
2. Host 300->340, STEP_MAX=16, ack after 3 clocks -> writes codes 316, 332, 340 in order, each separated by the settle interval; cur_code ends at 340.
3. Same-cycle host_valid=1 (code 500) and comp_valid=1 (code 450) -> target_code=500. With comp_enable=0, comp code 450 alone -> target unchanged.
4. host_code=900 -> target_code=680 with a one-cycle clamp_pulse. host_code=50 -> target_code=200 with clamp_pulse.
5. dac_ack withheld, ACK_TIMEOUT=20 -> dac_req falls on clock 20, ack_err=1, cur_code unchanged. After settle, the same dac_data is re-requested; err_clr clears ack_err.
6. rst_n low during WAIT_ACK -> dac_req=0 at once; after release, the init write of code 400 repeats, and host_ready is low throughout WAIT_ACK.

Source files
------------

// File: rtl/apd_hv_dac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : apd_hv_dac_sched
//  Brief    : Arbitrates host/compensation setpoints for the APD HV DAC and
//             ramps the DAC code in bounded, settled, acknowledged steps.
//  Revision : 1.0 - initial release
// ============================================================================
module apd_hv_dac_sched #(
  parameter int CODE_MIN      = 200,
  parameter int CODE_MAX      = 680,
  parameter int INIT_CODE     = 400,
  parameter int STEP_MAX      = 16,
  parameter int SETTLE_CYCLES = 10_000,
  parameter int ACK_TIMEOUT   = 65_535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_valid,
  input  logic [9:0]  host_code,
  output logic        host_ready,
  input  logic        comp_valid,
  input  logic [9:0]  comp_code,
  input  logic        comp_enable,
  output logic        dac_req,
  output logic [15:0] dac_data,
  input  logic        dac_ack,
  output logic [9:0]  cur_code,
  output logic [9:0]  target_code,
  output logic        busy,
  output logic        clamp_pulse,
  output logic        ack_err,
  input  logic        err_clr
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WAIT_ACK = 2'd1;
  localparam logic [1:0] c_SETTLE   = 2'd2;

  localparam int c_SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int c_TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [9:0]         c_CODE_MIN  = 10'(CODE_MIN);
  localparam logic [9:0]         c_CODE_MAX  = 10'(CODE_MAX);
  localparam logic [9:0]         c_INIT_CODE = 10'(INIT_CODE);
  localparam logic [9:0]         c_STEP_U    = 10'(STEP_MAX);
  localparam logic signed [10:0] c_STEP_S    = 11'(STEP_MAX);
  localparam logic [c_SW-1:0]    c_SETTLE_LD = c_SW'(SETTLE_CYCLES);
  localparam logic [c_TW-1:0]    c_TMO_LAST  = c_TW'(ACK_TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [9:0]      r_cur;
  logic [9:0]      r_target;
  logic            r_init_pending;
  logic            r_dac_req;
  logic [15:0]     r_dac_data;
  logic            r_clamp_pulse;
  logic            r_ack_err;
  logic [c_SW-1:0] r_settle_cnt;
  logic [c_TW-1:0] r_timer;

  logic                w_ready;
  logic                w_host_acc;
  logic                w_comp_acc;
  logic                w_accept;
  logic [9:0]          w_req_code;
  logic                w_req_lo;
  logic                w_req_hi;
  logic [9:0]          w_req_clamped;
  logic signed [10:0]  w_diff;
  logic [9:0]          w_step_code;
  logic                w_launch;
  logic                w_timeout;

  assign w_ready    = (r_state != c_WAIT_ACK);
  assign w_host_acc = w_ready & host_valid;
  // Host always wins a same-cycle contest; the losing comp request is dropped.
  assign w_comp_acc = w_ready & ~host_valid & comp_valid & comp_enable;
  assign w_accept   = w_host_acc | w_comp_acc;

  assign w_req_code    = host_valid ? host_code : comp_code;
  assign w_req_lo      = (w_req_code < c_CODE_MIN);
  assign w_req_hi      = (w_req_code > c_CODE_MAX);
  assign w_req_clamped = w_req_lo ? c_CODE_MIN : (w_req_hi ? c_CODE_MAX : w_req_code);

  assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_cur});

  always_comb begin
    w_step_code = r_cur;
    if (r_init_pending) begin
      w_step_code = r_cur;
    end else if (w_diff > c_STEP_S) begin
      w_step_code = r_cur + c_STEP_U;
    end else if (w_diff < -c_STEP_S) begin
      w_step_code = r_cur - c_STEP_U;
    end else begin
      w_step_code = r_target;
    end
  end

  assign w_launch  = (r_state == c_IDLE) & (r_init_pending | (r_cur != r_target));
  // An ack landing on the final timer cycle takes priority over the timeout.
  assign w_timeout = (r_state == c_WAIT_ACK) & ~dac_ack & (r_timer == c_TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_IDLE;
      r_cur          <= c_INIT_CODE;
      r_target       <= c_INIT_CODE;
      r_init_pending <= 1'b1;
      r_dac_req      <= 1'b0;
      r_dac_data     <= 16'd0;
      r_clamp_pulse  <= 1'b0;
      r_ack_err      <= 1'b0;
      r_settle_cnt   <= '0;
      r_timer        <= '0;
    end else begin
      r_clamp_pulse <= w_accept & (w_req_lo | w_req_hi);
      if (w_accept) begin
        r_target <= w_req_clamped;
      end

      if (w_timeout) begin
        r_ack_err <= 1'b1;
      end else if (err_clr) begin
        r_ack_err <= 1'b0;
      end

      case (r_state)
        c_IDLE: begin
          if (w_launch) begin
            r_dac_data <= {1'b1, 3'd0, w_step_code, 2'd0};
            r_dac_req  <= 1'b1;
            r_timer    <= '0;
            r_state    <= c_WAIT_ACK;
          end
        end
        c_WAIT_ACK: begin
          if (dac_ack) begin
            r_dac_req      <= 1'b0;
            r_cur          <= r_dac_data[11:2];
            r_init_pending <= 1'b0;
            r_settle_cnt   <= c_SETTLE_LD;
            r_state        <= c_SETTLE;
          end else if (w_timeout) begin
            // Code and init flag stay put so the same step is retried.
            r_dac_req    <= 1'b0;
            r_settle_cnt <= c_SETTLE_LD;
            r_state      <= c_SETTLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign host_ready  = rst_n & w_ready;
  assign dac_req     = r_dac_req;
  assign dac_data    = r_dac_data;
  assign cur_code    = r_cur;
  assign target_code = r_target;
  assign busy        = (r_state != c_IDLE);
  assign clamp_pulse = r_clamp_pulse;
  assign ack_err     = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_apd_hv_dac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apd_hv_dac_sched
//  Brief    : Directed self-checking bench for apd_hv_dac_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apd_hv_dac_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid = 1'b0;
  logic [9:0]  host_code = '0;
  logic        comp_valid = 1'b0;
  logic [9:0]  comp_code = '0;
  logic        comp_enable = 1'b0;
  logic        dac_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        host_ready;
  logic        dac_req;
  logic [15:0] dac_data;
  logic [9:0]  cur_code;
  logic [9:0]  target_code;
  logic        busy;
  logic        clamp_pulse;
  logic        ack_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  apd_hv_dac_sched #(
    .CODE_MIN(200), .CODE_MAX(680), .INIT_CODE(400), .STEP_MAX(16),
    .SETTLE_CYCLES(8), .ACK_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_code(host_code), .host_ready(host_ready),
    .comp_valid(comp_valid), .comp_code(comp_code), .comp_enable(comp_enable),
    .dac_req(dac_req), .dac_data(dac_data), .dac_ack(dac_ack),
    .cur_code(cur_code), .target_code(target_code), .busy(busy),
    .clamp_pulse(clamp_pulse), .ack_err(ack_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int word(input int code);
    return 32'h8000 | (code << 2);
  endfunction

  task automatic wait_req(input string tag, output int code);
    int n;
    n = 0;
    while (!dac_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dac_req) check({tag, " req wait"}, 0, 1);
    check({tag, " hdr"}, int'(dac_data[15:12]), 8);
    code = int'(dac_data[11:2]);
  endtask

  task automatic ack_after(input int d);
    repeat (d) @(negedge clk);
    dac_ack = 1'b1;
    @(negedge clk);
    dac_ack = 1'b0;
  endtask

  task automatic host_req(input int code);
    host_valid = 1'b1;
    host_code  = 10'(code);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, " idle wait"}, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int code, n, t_ack, iters;
    int exp2[3] = '{316, 332, 340};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst host_ready", host_ready, 0);
    check("rst dac_req", dac_req, 0);
    check("rst dac_data", dac_data, 0);
    check("rst cur_code", cur_code, 400);
    check("rst target", target_code, 400);
    check("rst busy", busy, 0);
    check("rst ack_err", ack_err, 0);
    check("rst clamp", clamp_pulse, 0);

    // Init write right after release
    rst_n = 1'b1;
    @(negedge clk);
    check("init req", dac_req, 1);
    check("init data", dac_data, 32'h8640);
    check("init busy", busy, 1);
    check("init ready", host_ready, 0);
    ack_after(2);
    check("init cur", cur_code, 400);
    check("init req drop", dac_req, 0);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("init settle len", n, 9);

    // Ramp down to 300, then 300 -> 340 in bounded steps
    host_req(300);
    iters = 0;
    do begin
      wait_req("ramp300", code);
      ack_after(1);
      iters++;
    end while (code != 300 && iters < 12);
    check("ramp300 writes", iters, 7);
    wait_idle("ramp300");
    check("ramp300 cur", cur_code, 300);

    host_req(340);
    check("t2 target", target_code, 340);
    check("t2 req latency0", dac_req, 0);
    @(negedge clk);
    check("t2 req latency1", dac_req, 1);
    t_ack = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req("t2", code);
      check("t2 step code", code, exp2[i]);
      if (i > 0) check("t2 settle gap", cyc - t_ack, 10);
      ack_after(3);
      t_ack = cyc;
    end
    wait_idle("t2");
    check("t2 cur", cur_code, 340);

    // Manual mode drops comp; host beats comp in the same cycle
    comp_enable = 1'b0;
    comp_valid = 1'b1; comp_code = 10'd450;
    @(negedge clk);
    comp_valid = 1'b0;
    check("t3 comp off target", target_code, 340);
    @(negedge clk);
    check("t3 comp off busy", busy, 0);
    comp_enable = 1'b1;
    host_valid = 1'b1; host_code = 10'd500;
    comp_valid = 1'b1; comp_code = 10'd450;
    @(negedge clk);
    host_valid = 1'b0; comp_valid = 1'b0;
    check("t3 host wins", target_code, 500);
    check("t3 no clamp", clamp_pulse, 0);
    wait_req("t3", code);
    check("t3 step", dac_data, word(356));

    // Blocked during WAIT_ACK
    host_valid = 1'b1; host_code = 10'd900;
    check("t4 ready low", host_ready, 0);
    @(negedge clk);
    host_valid = 1'b0;
    check("t4 blocked target", target_code, 500);
    check("t4 blocked clamp", clamp_pulse, 0);
    ack_after(1);
    t_ack = cyc;

    // Clamping, accepted during SETTLE
    host_req(900);
    check("t4 clamp hi target", target_code, 680);
    check("t4 clamp hi pulse", clamp_pulse, 1);
    @(negedge clk);
    check("t4 pulse one cycle", clamp_pulse, 0);
    comp_valid = 1'b1; comp_code = 10'd450;
    @(negedge clk);
    comp_valid = 1'b0;
    check("t4 comp target", target_code, 450);
    check("t4 comp no clamp", clamp_pulse, 0);
    host_req(50);
    check("t4 clamp lo target", target_code, 200);
    check("t4 clamp lo pulse", clamp_pulse, 1);

    // Timeout with simultaneous err_clr (set wins), then retry
    wait_req("t5", code);
    check("t5 settle not cut", cyc - t_ack, 10);
    check("t5 step", code, 340);
    check("t5 err before", ack_err, 0);
    n = 0;
    while (dac_req && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 19) err_clr = 1'b1;
    end
    err_clr = 1'b0;
    check("t5 timeout clk", n, 20);
    check("t5 ack_err set", ack_err, 1);
    check("t5 cur kept", cur_code, 356);
    t_ack = cyc;
    wait_req("t5 retry", code);
    check("t5 retry gap", cyc - t_ack, 10);
    check("t5 retry data", dac_data, word(340));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5 err_clr", ack_err, 0);
    ack_after(18);
    check("t5 ack at limit req", dac_req, 0);
    check("t5 ack at limit err", ack_err, 0);
    check("t5 ack at limit cur", cur_code, 340);

    // Reset during WAIT_ACK
    wait_req("t6", code);
    check("t6 step", code, 324);
    check("t6 ready low", host_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async req", dac_req, 0);
    check("t6 async cur", cur_code, 400);
    check("t6 async target", target_code, 400);
    check("t6 ready in rst", host_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 init req", dac_req, 1);
    check("t6 init data", dac_data, 32'h8640);
    @(negedge clk);
    check("t6 init ready low", host_ready, 0);
    ack_after(1);
    wait_idle("t6");
    check("t6 cur", cur_code, 400);
    check("t6 ready idle", host_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
